// File: rtl/debug_loader.sv
// debug_loader: UART-side debug controller that loads instruction memory, runs or steps the pipeline and reports the PC.
// Optional load inactivity timeout is built only when DEBUG_LOADER_TIMEOUT_EN is defined.
module debug_loader #(
    parameter int unsigned        NB_INST     = 32,
    parameter int unsigned        NB_ADDR     = 32,
    parameter int unsigned        NB_BYTE     = 8,
    parameter int unsigned        MAX_INST    = 64,
    parameter logic [NB_INST-1:0] HALT_INST   = 32'hFFFF_FFFF,
    parameter logic [NB_BYTE-1:0] CMD_LOAD    = 8'h4C,
    parameter logic [NB_BYTE-1:0] CMD_RUN     = 8'h52,
    parameter logic [NB_BYTE-1:0] CMD_STEP    = 8'h53,
    parameter int unsigned        TIMEOUT_CYC = 1000000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    input  logic [NB_ADDR-1:0] i_pc,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_write,
    output logic [NB_INST-1:0] o_instruction,
    output logic [NB_ADDR-1:0] o_address,
    output logic               o_enable,
    output logic               o_busy
);

    localparam int unsigned INST_BYTES = NB_INST / NB_BYTE;
    localparam int unsigned PC_BYTES   = NB_ADDR / NB_BYTE;
    localparam int unsigned CNT_W      = $clog2((INST_BYTES > PC_BYTES) ? INST_BYTES : PC_BYTES) + 1;
    localparam int unsigned PTR_W      = $clog2(MAX_INST + 1);

    localparam logic [CNT_W-1:0]   LAST_INST_BYTE = CNT_W'(INST_BYTES - 1);
    localparam logic [CNT_W-1:0]   LAST_PC_BYTE   = CNT_W'(PC_BYTES - 1);
    localparam logic [PTR_W-1:0]   LAST_PTR       = PTR_W'(MAX_INST - 1);
    localparam logic [NB_ADDR-1:0] LAST_ADDR      = NB_ADDR'((MAX_INST - 1) * 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOAD_WRITE,
        S_RUN,
        S_STEP,
        S_SEND_LATCH,
        S_SEND_WAIT
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_byte_cnt;
    logic [PTR_W-1:0]   r_ptr;
    logic [NB_ADDR-1:0] r_halt_addr;
    logic [NB_INST-1:0] r_shift;
    logic [NB_ADDR-1:0] r_pc_sh;
    logic               r_write;
    logic [NB_INST-1:0] r_instruction;
    logic [NB_ADDR-1:0] r_address;
    logic [NB_BYTE-1:0] r_tx_data;
    logic               r_tx_start;

    logic [NB_INST-1:0] w_next_word;
    logic [NB_ADDR-1:0] w_ptr_addr;
    logic               w_pc_hit;
    logic               w_timeout;

    assign w_next_word = {r_shift[NB_INST-NB_BYTE-1:0], i_rx_data};
    assign w_ptr_addr  = NB_ADDR'(r_ptr) << 2;
    assign w_pc_hit    = (i_pc == r_halt_addr);

`ifdef DEBUG_LOADER_TIMEOUT_EN
    localparam int unsigned        TO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] r_to_cnt;

    // Counts idle cycles inside LOAD; any received byte or leaving LOAD restarts it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_to_cnt <= '0;
        end else if ((r_state != S_LOAD) || i_rx_done) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state == S_LOAD) && !i_rx_done && (r_to_cnt == TO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_byte_cnt    <= '0;
            r_ptr         <= '0;
            r_halt_addr   <= '0;
            r_shift       <= '0;
            r_pc_sh       <= '0;
            r_write       <= 1'b0;
            r_instruction <= '0;
            r_address     <= '0;
            r_tx_data     <= '0;
            r_tx_start    <= 1'b0;
        end else begin
            r_write    <= 1'b0;
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_rx_done) begin
                        if (i_rx_data == CMD_LOAD) begin
                            r_state    <= S_LOAD;
                            r_ptr      <= '0;
                            r_byte_cnt <= '0;
                        end else if (i_rx_data == CMD_RUN) begin
                            r_state <= S_RUN;
                        end else if (i_rx_data == CMD_STEP) begin
                            r_state <= S_STEP;
                        end
                    end
                end
                S_LOAD: begin
                    if (i_rx_done) begin
                        r_shift <= w_next_word;
                        if (r_byte_cnt == LAST_INST_BYTE) begin
                            r_state       <= S_LOAD_WRITE;
                            r_write       <= 1'b1;
                            r_instruction <= w_next_word;
                            r_address     <= w_ptr_addr;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state    <= S_IDLE;
                        r_shift    <= '0;
                        r_byte_cnt <= '0;
                    end
                end
                S_LOAD_WRITE: begin
                    // Write strobe, data and address are all visible during this cycle.
                    r_ptr      <= r_ptr + 1'b1;
                    r_byte_cnt <= '0;
                    if (r_shift == HALT_INST) begin
                        r_halt_addr <= w_ptr_addr;
                        r_state     <= S_IDLE;
                    end else if (r_ptr == LAST_PTR) begin
                        r_halt_addr <= LAST_ADDR;
                        r_state     <= S_IDLE;
                    end else begin
                        r_state <= S_LOAD;
                    end
                end
                S_RUN: begin
                    if (w_pc_hit) begin
                        r_state <= S_SEND_LATCH;
                    end
                end
                S_STEP: begin
                    r_state <= S_SEND_LATCH;
                end
                S_SEND_LATCH: begin
                    r_tx_data  <= i_pc[NB_ADDR-1 -: NB_BYTE];
                    r_pc_sh    <= i_pc << NB_BYTE;
                    r_tx_start <= 1'b1;
                    r_byte_cnt <= '0;
                    r_state    <= S_SEND_WAIT;
                end
                S_SEND_WAIT: begin
                    if (i_tx_done) begin
                        if (r_byte_cnt == LAST_PC_BYTE) begin
                            r_byte_cnt <= '0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            r_tx_data  <= r_pc_sh[NB_ADDR-1 -: NB_BYTE];
                            r_pc_sh    <= r_pc_sh << NB_BYTE;
                            r_tx_start <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Run enable drops in the very cycle the PC reaches the halt address.
    assign o_enable      = (r_state == S_STEP) || ((r_state == S_RUN) && !w_pc_hit);
    assign o_busy        = (r_state != S_IDLE);
    assign o_write       = r_write;
    assign o_instruction = r_instruction;
    assign o_address     = r_address;
    assign o_tx_data     = r_tx_data;
    assign o_tx_start    = r_tx_start;

endmodule

// File: tb/tb_debug_loader.sv
// Directed, table-driven bench for debug_loader: command decode, load, run, step, full memory and load timeout.
module tb_debug_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic        tx_done = 1'b0;
    logic        pc_auto = 1'b0;
    logic [31:0] pc_fixed = 32'h0;
    logic [31:0] pc_model;
    logic [31:0] pc;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        wr;
    logic [31:0] instr;
    logic [31:0] addr;
    logic        en;
    logic        busy;

    int n_total = 0;
    int n_pass  = 0;
    int wr_cnt  = 0;
    int en_cnt  = 0;
    logic [31:0] wr_addr_log [0:255];
    logic [31:0] wr_data_log [0:255];

    always #5 clk = ~clk;

    assign pc = pc_auto ? pc_model : pc_fixed;

    debug_loader #(.TIMEOUT_CYC(100)) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_rx_data    (rx_data),
        .i_rx_done    (rx_done),
        .i_tx_done    (tx_done),
        .i_pc         (pc),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .o_write      (wr),
        .o_instruction(instr),
        .o_address    (addr),
        .o_enable     (en),
        .o_busy       (busy)
    );

    // Pipeline PC model: advances by 4 on every enabled cycle.
    always @(posedge clk) begin
        if (!pc_auto) pc_model <= 32'h0;
        else if (en)  pc_model <= pc_model + 32'd4;
    end

    always @(negedge clk) begin
        if (wr) begin
            wr_addr_log[wr_cnt[7:0]] = addr;
            wr_data_log[wr_cnt[7:0]] = instr;
            wr_cnt = wr_cnt + 1;
        end
        if (en) en_cnt = en_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] w);
        logic [31:0] sh;
        for (int k = 3; k >= 0; k--) begin
            sh = w >> (8 * k);
            send_byte(sh[7:0]);
            tick();
        end
    endtask

    // Serves the 4 PC bytes, checking each value and that no byte starts before its predecessor's done.
    task automatic serve_tx(input string name, input logic [31:0] exp, input bit stray);
        logic [31:0] sh;
        int extra;
        bit got;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            got = 1'b0;
            for (int c = 0; c < 50 && !got; c++) begin
                @(negedge clk);
                if (tx_start) got = 1'b1;
            end
            check({name, " tx_start seen"}, {31'b0, got}, 32'd1);
            sh = exp >> (8 * (3 - i));
            check({name, " tx byte"}, {24'b0, tx_data}, {24'b0, sh[7:0]});
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (stray && c == 0) begin
                    rx_data = 8'h4C;
                    rx_done = 1'b1;
                end else begin
                    rx_done = 1'b0;
                end
                if (tx_start) extra++;
            end
            rx_done = 1'b0;
            @(posedge clk); #1 tx_done = 1'b1;
            @(posedge clk); #1 tx_done = 1'b0;
        end
        check({name, " tx gated by tx_done"}, extra, 32'd0);
        @(negedge clk);
        check({name, " busy after send"}, {31'b0, busy}, 32'd0);
        tick();
    endtask

    typedef struct {
        logic [7:0] cmd;
        logic       exp_busy;
        logic       exp_en;
    } vec_t;

    vec_t vecs [0:7];

    initial begin
        int w0, e0;
        vecs[0] = '{8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'h4C, 1'b1, 1'b0};
        vecs[2] = '{8'h52, 1'b1, 1'b0};
        vecs[3] = '{8'h53, 1'b1, 1'b1};
        vecs[4] = '{8'h6C, 1'b0, 1'b0};
        vecs[5] = '{8'hFF, 1'b0, 1'b0};
        vecs[6] = '{8'h4D, 1'b0, 1'b0};
        vecs[7] = '{8'h13, 1'b0, 1'b0};

        do_reset();
        @(negedge clk);
        check("reset write",   {31'b0, wr}, 32'd0);
        check("reset instr",   instr, 32'd0);
        check("reset addr",    addr, 32'd0);
        check("reset busy",    {31'b0, busy}, 32'd0);
        check("reset enable",  {31'b0, en}, 32'd0);
        check("reset txstart", {31'b0, tx_start}, 32'd0);
        tick();

        // Command decode table; halt address is 0 after reset and pc is 0, so 'R' never enables.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            send_byte(vecs[v].cmd);
            @(negedge clk);
            check($sformatf("decode %02h busy", vecs[v].cmd), {31'b0, busy}, {31'b0, vecs[v].exp_busy});
            check($sformatf("decode %02h enable", vecs[v].cmd), {31'b0, en}, {31'b0, vecs[v].exp_en});
            tick();
        end

        // Reset in the middle of a load.
        do_reset();
        send_byte(8'h4C); tick();
        send_byte(8'h20); tick();
        send_byte(8'h08); tick();
        rst = 1'b1;
        #2;
        check("midload rst write", {31'b0, wr}, 32'd0);
        check("midload rst instr", instr, 32'd0);
        check("midload rst txdata", {24'b0, tx_data}, 32'd0);
        check("midload rst busy", {31'b0, busy}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        e0 = en_cnt;
        send_byte(8'h53);
        serve_tx("step after reset", 32'h0, 1'b0);
        check("step after reset enables", en_cnt - e0, 32'd1);

        // Two-word load ending in the halt word.
        w0 = wr_cnt;
        send_byte(8'h4C); tick();
        load_word(32'h2008_0004);
        load_word(32'hFFFF_FFFF);
        check("load2 writes", wr_cnt - w0, 32'd2);
        check("load2 addr0", wr_addr_log[w0], 32'h0);
        check("load2 data0", wr_data_log[w0], 32'h2008_0004);
        check("load2 addr1", wr_addr_log[w0 + 1], 32'h4);
        check("load2 data1", wr_data_log[w0 + 1], 32'hFFFF_FFFF);
        @(negedge clk);
        check("load2 busy", {31'b0, busy}, 32'd0);
        tick();

        // Run to halt address 0x4 with the PC model.
        pc_auto = 1'b1;
        e0 = en_cnt;
        send_byte(8'h52);
        serve_tx("run", 32'h0000_0004, 1'b0);
        check("run enables", en_cnt - e0, 32'd1);
        pc_auto = 1'b0;
        tick();

        // Step with stray 'L' bytes during the send.
        pc_fixed = 32'h0000_0010;
        e0 = en_cnt;
        w0 = wr_cnt;
        send_byte(8'h53);
        serve_tx("step", 32'h0000_0010, 1'b1);
        check("step enables", en_cnt - e0, 32'd1);
        check("step no writes", wr_cnt - w0, 32'd0);

        // Fill memory with 64 non-halt words.
        w0 = wr_cnt;
        send_byte(8'h4C); tick();
        for (int i = 0; i < 64; i++) load_word(32'h1000_0000 + i);
        check("full writes", wr_cnt - w0, 32'd64);
        check("full last addr", wr_addr_log[w0 + 63], 32'h0000_00FC);
        check("full last data", wr_data_log[w0 + 63], 32'h1000_003F);
        @(negedge clk);
        check("full busy", {31'b0, busy}, 32'd0);
        tick();
        pc_fixed = 32'h0000_0020;
        e0 = en_cnt;
        send_byte(8'h53);
        serve_tx("step after full", 32'h0000_0020, 1'b0);
        check("step after full enables", en_cnt - e0, 32'd1);
        // Halt address is now 0xFC; a run starting there never enables.
        pc_fixed = 32'h0000_00FC;
        e0 = en_cnt;
        send_byte(8'h52);
        serve_tx("run at halt", 32'h0000_00FC, 1'b0);
        check("run at halt enables", en_cnt - e0, 32'd0);

        // Load inactivity after 3 bytes.
        do_reset();
        w0 = wr_cnt;
        send_byte(8'h4C); tick();
        send_byte(8'h11); tick();
        send_byte(8'h22); tick();
        send_byte(8'h33);
        repeat (90) @(negedge clk);
        check("timeout busy before limit", {31'b0, busy}, 32'd1);
        repeat (15) @(negedge clk);
        check("timeout no write", wr_cnt - w0, 32'd0);
`ifdef DEBUG_LOADER_TIMEOUT_EN
        check("timeout busy after limit", {31'b0, busy}, 32'd0);
        tick();
        pc_fixed = 32'h0000_0008;
        e0 = en_cnt;
        send_byte(8'h53);
        serve_tx("step after timeout", 32'h0000_0008, 1'b0);
        check("step after timeout enables", en_cnt - e0, 32'd1);
`else
        check("no timeout busy after limit", {31'b0, busy}, 32'd1);
        tick();
        do_reset();
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
